mem_port_arbiter: RTL and testbench

Sequential controller that shares one byte-wide, single-port memory between the instruction-fetch port and the load/store data port of the pipelined RISC-V core. It accepts 32-bit word requests from the two requesters, arbitrates between them, and serialises each word into four byte beats on the memory. It returns assembled little-endian read data or a write acknowledge. It sits between the IF/MEM pipeline stages and the unified byte memory; the pipeline stalls on its handshake.

---
 rtl/mem_arb_pkg.sv | 10 +
 rtl/arb_rr2.sv | 27 ++
 rtl/mem_port_arbiter.sv | 116 +++++++++++
 tb/tb_mem_port_arbiter.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the IF/data memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {IDLE, BEAT, DONE} state_t;
  typedef enum logic       {REQ_IF, REQ_D}    req_id_t;

  localparam int BEATS  = 4;
  localparam int BYTE_W = 8;

endpackage

// File: rtl/arb_rr2.sv
// Two-way combinational picker: a lone requester wins; ties go to the port
// not granted last time, or always to the data port in fixed-priority mode.
module arb_rr2
  import mem_arb_pkg::*;
#(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic    req_if,
  input  logic    req_d,
  input  req_id_t last_grant,
  output logic [1:0] grant   // bit 0 = IF, bit 1 = data
);

  // one-hot winner selection
  always_comb begin
    grant = 2'b00;
    if (req_if && req_d) begin
      if (FIXED_PRIO || last_grant == REQ_IF) grant = 2'b10;
      else                                    grant = 2'b01;
    end else if (req_if) begin
      grant = 2'b01;
    end else if (req_d) begin
      grant = 2'b10;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares a byte-wide single-port memory between the fetch and data ports.
// Each accepted word request becomes four byte beats, then a one-cycle
// rvalid pulse to the requester that owns the transaction.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter bit FIXED_PRIO = 1'b0,
  parameter int ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);

  state_t            state, state_nx;
  logic [1:0]        beat;
  req_id_t           id_q, last_grant;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [31:0]       wdata_q, rdata_q, rdata_nx;
  logic [31:0]       if_rdata_q, d_rdata_q;
  logic [1:0]        pick;
  logic              accept;

  arb_rr2 #(.FIXED_PRIO(FIXED_PRIO)) u_arb (
    .req_if     (if_req),
    .req_d      (d_req),
    .last_grant (last_grant),
    .grant      (pick)
  );

  // grants only from IDLE, and never while reset is held
  assign if_gnt = rst_n && (state == IDLE) && pick[0];
  assign d_gnt  = rst_n && (state == IDLE) && pick[1];
  assign accept = if_gnt || d_gnt;

  assign if_rvalid = (state == DONE) && (id_q == REQ_IF);
  assign d_rvalid  = (state == DONE) && (id_q == REQ_D);
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;

  // next state, memory drive and read-byte merge
  always_comb begin
    state_nx  = state;
    mem_addr  = addr_q;
    mem_we    = 1'b0;
    mem_wdata = '0;
    rdata_nx  = rdata_q;
    case (state)
      IDLE: if (accept) state_nx = BEAT;
      BEAT: begin
        mem_addr = addr_q + ADDR_W'(beat);
        if (we_q) begin
          mem_we    = 1'b1;
          mem_wdata = wdata_q[BYTE_W*beat +: BYTE_W];
        end else begin
          rdata_nx[BYTE_W*beat +: BYTE_W] = mem_rdata;
        end
        if (beat == 2'(BEATS-1)) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // transaction capture, beat sequencing and per-port read data holding
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      beat       <= '0;
      id_q       <= REQ_IF;
      last_grant <= REQ_IF;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && accept) begin
        id_q       <= d_gnt ? REQ_D : REQ_IF;
        last_grant <= d_gnt ? REQ_D : REQ_IF;
        addr_q     <= d_gnt ? d_addr : if_addr;
        we_q       <= d_gnt && d_we;
        wdata_q    <= d_gnt ? d_wdata : '0;
        rdata_q    <= '0;
        beat       <= '0;
      end else if (state == BEAT) begin
        rdata_q <= rdata_nx;
        beat    <= beat + 2'd1;
        // publish the assembled word as we enter DONE; stores publish 0
        if (beat == 2'(BEATS-1)) begin
          if (id_q == REQ_IF) if_rdata_q <= rdata_nx;
          else                d_rdata_q  <= rdata_nx;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0;
  logic        if_gnt, if_rvalid, d_gnt, d_rvalid, mem_we;
  logic [31:0] if_rdata, d_rdata, mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;

  // fixed-priority instance
  logic        f_if_req = 1'b0, f_d_req = 1'b0;
  logic        f_if_gnt, f_if_rvalid, f_d_gnt, f_d_rvalid, f_mem_we;
  logic [31:0] f_if_rdata, f_d_rdata, f_mem_addr;
  logic [7:0]  f_mem_wdata;
  logic [7:0]  f_mem_rdata = 8'h00;

  // byte memory model plus backdoor preload port
  logic [7:0]  mem [256];
  logic        tb_we = 1'b0;
  logic [7:0]  tb_a = '0, tb_d = '0;

  int npass = 0, nfail = 0, ntotal = 0;

  typedef struct { logic is_d; logic [31:0] rdata; } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[7:0]];

  always @(posedge clk) begin
    if (mem_we)     mem[mem_addr[7:0]] <= mem_wdata;
    else if (tb_we) mem[tb_a]          <= tb_d;
  end

  mem_port_arbiter #(.FIXED_PRIO(1'b0), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  mem_port_arbiter #(.FIXED_PRIO(1'b1), .ADDR_W(32)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .if_req(f_if_req), .if_addr(32'h0), .if_gnt(f_if_gnt),
    .if_rvalid(f_if_rvalid), .if_rdata(f_if_rdata),
    .d_req(f_d_req), .d_we(1'b0), .d_addr(32'h40), .d_wdata(32'h0),
    .d_gnt(f_d_gnt), .d_rvalid(f_d_rvalid), .d_rdata(f_d_rdata),
    .mem_addr(f_mem_addr), .mem_we(f_mem_we), .mem_wdata(f_mem_wdata),
    .mem_rdata(f_mem_rdata)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    tb_we = 1'b1; tb_a = a; tb_d = d;
    @(posedge clk); #1;
    tb_we = 1'b0;
  endtask

  // one word transaction: request, beat-by-beat memory check, response
  task automatic xact(input bit is_d, input bit we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [31:0] exp_rdata);
    int n;
    logic [31:0] ea;
    logic [7:0]  eb;
    exp_t e;
    if (is_d) begin d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata; end
    else begin if_req = 1'b1; if_addr = addr; end
    n = 0;
    @(negedge clk);
    while (!(is_d ? d_gnt : if_gnt) && n < 20) begin n++; @(negedge clk); end
    chk("gnt_timeout", 64'(n < 20), 64'd1);
    if (n < 20) begin
      sb.push_back('{is_d, exp_rdata});
      @(posedge clk); #1;
      d_req = 1'b0; if_req = 1'b0;
      for (int b = 0; b < 4; b++) begin
        @(negedge clk);
        ea = addr + 32'(b);
        eb = we ? wdata[8*b +: 8] : 8'h00;
        chk("beat_addr", 64'(mem_addr), 64'(ea));
        chk("beat_we", 64'(mem_we), 64'(we));
        chk("beat_wdata", 64'(mem_wdata), 64'(eb));
      end
      @(negedge clk);
      e = sb.pop_front();
      chk("rvalid", 64'(e.is_d ? d_rvalid : if_rvalid), 64'd1);
      chk("other_rvalid", 64'(e.is_d ? if_rvalid : d_rvalid), 64'd0);
      chk("rdata", 64'(e.is_d ? d_rdata : if_rdata), 64'(e.rdata));
      @(posedge clk); #1;
    end else begin
      d_req = 1'b0; if_req = 1'b0;
    end
  endtask

  initial begin
    int gcyc[$];
    bit gisd[$];
    int fd, fi;

    // reset state with both requesters already asserting
    if_req = 1'b1; if_addr = 32'h0; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10;
    f_if_req = 1'b1; f_d_req = 1'b1;
    @(negedge clk);
    chk("rst_if_gnt", 64'(if_gnt), 64'd0);
    chk("rst_d_gnt", 64'(d_gnt), 64'd0);
    chk("rst_rvalid", 64'({if_rvalid, d_rvalid}), 64'd0);
    chk("rst_rdata", 64'({if_rdata, d_rdata}), 64'd0);
    chk("rst_mem", 64'({mem_we, mem_addr, mem_wdata}), 64'd0);
    chk("rst_fp_gnt", 64'({f_if_gnt, f_d_gnt}), 64'd0);

    // tie arbitration from reset: round-robin and fixed priority side by side
    @(posedge clk); #1;
    rst_n = 1'b1;
    fd = 0; fi = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (if_gnt || d_gnt) begin gcyc.push_back(c); gisd.push_back(d_gnt); end
      if (f_d_gnt)  fd++;
      if (f_if_gnt) fi++;
    end
    @(posedge clk); #1;
    if_req = 1'b0; d_req = 1'b0; f_if_req = 1'b0; f_d_req = 1'b0;
    chk("rr_count", 64'(gcyc.size()), 64'd5);
    if (gcyc.size() == 5) begin
      for (int k = 0; k < 5; k++) begin
        chk("rr_cycle", 64'(gcyc[k]), 64'(6 * k));
        chk("rr_port", 64'(gisd[k]), 64'(k % 2 == 0));
      end
    end
    chk("fp_d_gnts", 64'(fd), 64'd5);
    chk("fp_if_gnts", 64'(fi), 64'd0);

    // store, then memory contents
    xact(1'b1, 1'b1, 32'h10, 32'h11223344, 32'h0);
    chk("store_mem", 64'({mem[8'h10], mem[8'h11], mem[8'h12], mem[8'h13]}), 64'h44332211);

    // fetch
    poke(8'h00, 8'h13); poke(8'h01, 8'h05); poke(8'h02, 8'h50); poke(8'h03, 8'h00);
    xact(1'b0, 1'b0, 32'h0, 32'h0, 32'h00500513);

    // load back the stored word, then rdata must hold after the pulse
    xact(1'b1, 1'b0, 32'h10, 32'h0, 32'h11223344);
    repeat (3) @(negedge clk);
    chk("hold_d_rdata", 64'(d_rdata), 64'h11223344);
    chk("hold_if_rdata", 64'(if_rdata), 64'h00500513);
    chk("hold_rvalid", 64'({if_rvalid, d_rvalid}), 64'd0);
    @(posedge clk); #1;

    // address wrap on a load
    poke(8'hFE, 8'h78); poke(8'hFF, 8'h56);
    xact(1'b1, 1'b0, 32'hFFFFFFFE, 32'h0, 32'h05135678);

    // reset during beat 2 of a store
    poke(8'h20, 8'h5A); poke(8'h21, 8'h5A); poke(8'h22, 8'h5A); poke(8'h23, 8'h5A);
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'hAABBCCDD;
    @(negedge clk);
    chk("mrst_gnt", 64'(d_gnt), 64'd1);
    @(posedge clk); #1;
    d_req = 1'b0;
    @(posedge clk); #1;                    // beat 1
    @(posedge clk); #1;                    // beat 2
    rst_n = 1'b0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20;
    @(negedge clk);
    chk("mrst_gnt_forced", 64'({if_gnt, d_gnt}), 64'd0);
    chk("mrst_mem", 64'({mem_we, mem_addr, mem_wdata}), 64'd0);
    chk("mrst_rdata", 64'({if_rdata, d_rdata}), 64'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("mrst_no_rvalid", 64'({if_rvalid, d_rvalid}), 64'd0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("mrst_regrant", 64'(d_gnt), 64'd1);
    chk("mrst_bytes", 64'({mem[8'h20], mem[8'h21], mem[8'h22], mem[8'h23]}), 64'hDDCC5A5A);
    @(posedge clk); #1;
    d_req = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("mrst_load_rvalid", 64'(d_rvalid), 64'd1);
    chk("mrst_load_rdata", 64'(d_rdata), 64'h5A5ACCDD);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
